fifo_byte_packer: RTL and testbench

- Upstream feeder for the 8-deep x 32-bit FIFO.
- Accepts a byte stream over a valid/ready handshake and packs four bytes into one 32-bit word.
- Writes each word into the FIFO through its wr_en/data_in/full interface.
- A flush input pushes a partially filled word early, so short messages are not held back.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/packer_lane_sel.sv | 22 ++
 rtl/fifo_byte_packer.sv | 88 ++++++++
 tb/tb_fifo_byte_packer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the byte packer feeding the 8x32 FIFO.
package fifo_pkg;

   localparam int unsigned FIFO_DATA_W = 32;
   localparam int unsigned FIFO_BYTE_W = 8;
   localparam int unsigned FIFO_BYTES  = 4;
   localparam int unsigned LANE_IDX_W  = 2;
   localparam int unsigned NBYTES_W    = 3;

   typedef enum logic {
      FILL = 1'b0,
      PUSH = 1'b1
   } packer_state_e;

endpackage

// File: rtl/packer_lane_sel.sv
// Decodes the current fill count into a one-hot lane write-enable.
// FIFO_PACKER_BIG_ENDIAN_EN: first byte lands in the MSB lane instead of the LSB lane.
module packer_lane_sel
   import fifo_pkg::*;
(
   input  logic [LANE_IDX_W-1:0] byte_cnt,
   input  logic                  en,
   output logic [FIFO_BYTES-1:0] lane_we_c
);

   always_comb begin
      lane_we_c = '0;
      if (en) begin
`ifdef FIFO_PACKER_BIG_ENDIAN_EN
         lane_we_c[LANE_IDX_W'(FIFO_BYTES - 1) - byte_cnt] = 1'b1;
`else
         lane_we_c[byte_cnt] = 1'b1;
`endif
      end
   end

endmodule

// File: rtl/fifo_byte_packer.sv
// Packs a valid/ready byte stream into 32-bit words and writes them into the FIFO.
// Lane order is selected by FIFO_PACKER_BIG_ENDIAN_EN inside packer_lane_sel.
module fifo_byte_packer
   import fifo_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FIFO_BYTE_W-1:0] byte_in,
   input  logic                   byte_valid,
   output logic                   byte_ready,
   input  logic                   flush,
   input  logic                   fifo_full,
   output logic                   fifo_wr_en,
   output logic [FIFO_DATA_W-1:0] fifo_data,
   output logic [NBYTES_W-1:0]    word_bytes,
   output logic [LANE_IDX_W-1:0]  byte_cnt,
   output logic [CNT_W-1:0]       word_count
);

   packer_state_e          state;
   logic [FIFO_DATA_W-1:0] shift_word;

   logic                   accept_c;
   logic [FIFO_BYTES-1:0]  lane_we_c;
   logic [FIFO_DATA_W-1:0] merged_c;
   logic [NBYTES_W-1:0]    held_c;
   logic                   push_c;

   assign accept_c   = (state == FILL) && byte_valid;
   assign byte_ready = (state == FILL);
   // Write strobe must track fifo_full in the same cycle so a word is never dropped.
   assign fifo_wr_en = (state == PUSH) && !fifo_full && !rst;

   packer_lane_sel u_lane_sel (
      .byte_cnt  (byte_cnt),
      .en        (accept_c),
      .lane_we_c (lane_we_c)
   );

   // Current partial word with this cycle's byte merged into its lane.
   always_comb begin
      merged_c = shift_word;
      for (int k = 0; k < int'(FIFO_BYTES); k++) begin
         if (lane_we_c[k]) merged_c[k*FIFO_BYTE_W +: FIFO_BYTE_W] = byte_in;
      end
   end

   assign held_c = NBYTES_W'(byte_cnt) + NBYTES_W'(accept_c);
   assign push_c = (state == FILL) &&
                   ((held_c == NBYTES_W'(FIFO_BYTES)) || (flush && (held_c != '0)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         shift_word <= '0;
         byte_cnt   <= '0;
         fifo_data  <= '0;
         word_bytes <= '0;
         word_count <= '0;
      end else begin
         unique case (state)
            FILL: begin
               if (push_c) begin
                  fifo_data  <= merged_c;
                  word_bytes <= held_c;
                  shift_word <= '0;
                  byte_cnt   <= '0;
                  state      <= PUSH;
               end else if (accept_c) begin
                  shift_word <= merged_c;
                  byte_cnt   <= byte_cnt + LANE_IDX_W'(1);
               end
            end
            PUSH: begin
               if (fifo_wr_en) begin
                  word_count <= word_count + CNT_W'(1);
                  word_bytes <= '0;
                  state      <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Self-checking bench for fifo_byte_packer; uses a 2-bit word counter to reach the wrap point.
module tb_fifo_byte_packer;

   localparam int unsigned CNT_W = 2;

   typedef logic [7:0] bq_t[$];

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic             flush;
   logic             fifo_full;
   logic             fifo_wr_en;
   logic [31:0]      fifo_data;
   logic [2:0]       word_bytes;
   logic [1:0]       byte_cnt;
   logic [CNT_W-1:0] word_count;

   int n_cmp = 0;
   int n_bad = 0;

   fifo_byte_packer #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .flush      (flush),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_data  (fifo_data),
      .word_bytes (word_bytes),
      .byte_cnt   (byte_cnt),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Reference packing: byte k in arrival order goes to its lane, unfilled lanes stay zero.
   function automatic logic [31:0] pack(input bq_t q);
      logic [31:0] w = '0;
      foreach (q[k]) begin
`ifdef FIFO_PACKER_BIG_ENDIAN_EN
         w[31-8*k -: 8] = q[k];
`else
         w[8*k +: 8] = q[k];
`endif
      end
      return w;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; byte_in = '0; byte_valid = 1'b0; flush = 1'b0; fifo_full = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_cmp++; if (byte_ready !== 1'b1) begin n_bad++; $display("FAIL reset.byte_ready got=%0b want=1", byte_ready); end
      n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset.wr_en got=%0b want=0", fifo_wr_en); end
      n_cmp++; if (fifo_data !== 32'h0) begin n_bad++; $display("FAIL reset.fifo_data got=%h want=0", fifo_data); end
      n_cmp++; if (word_bytes !== 3'd0) begin n_bad++; $display("FAIL reset.word_bytes got=%0d want=0", word_bytes); end
      n_cmp++; if (byte_cnt !== 2'd0) begin n_bad++; $display("FAIL reset.byte_cnt got=%0d want=0", byte_cnt); end
      n_cmp++; if (word_count !== '0) begin n_bad++; $display("FAIL reset.word_count got=%0d want=0", word_count); end
      cyc();
   endtask

   task automatic test_full_word();
      bq_t q = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      foreach (q[i]) begin
         byte_in = q[i]; byte_valid = 1'b1;
         @(negedge clk);
         n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL full_word.early_wr i=%0d got=%0b want=0", i, fifo_wr_en); end
         n_cmp++; if (byte_cnt !== 2'(i)) begin n_bad++; $display("FAIL full_word.byte_cnt got=%0d want=%0d", byte_cnt, i); end
         cyc();
      end
      byte_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL full_word.wr_en got=%0b want=1", fifo_wr_en); end
      n_cmp++; if (fifo_data !== pack(q)) begin n_bad++; $display("FAIL full_word.data got=%h want=%h", fifo_data, pack(q)); end
      n_cmp++; if (word_bytes !== 3'd4) begin n_bad++; $display("FAIL full_word.word_bytes got=%0d want=4", word_bytes); end
      n_cmp++; if (byte_ready !== 1'b0) begin n_bad++; $display("FAIL full_word.ready got=%0b want=0", byte_ready); end
      cyc();
      @(negedge clk);
      n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL full_word.wr_once got=%0b want=0", fifo_wr_en); end
      n_cmp++; if (word_count !== CNT_W'(1)) begin n_bad++; $display("FAIL full_word.word_count got=%0d want=1", word_count); end
      n_cmp++; if (word_bytes !== 3'd0) begin n_bad++; $display("FAIL full_word.bytes_clr got=%0d want=0", word_bytes); end
   endtask

   task automatic test_flush();
      bq_t q = '{8'hAA, 8'hBB};
      bq_t one = '{8'h5A};
      do_reset();
      // flush with nothing held is ignored
      flush = 1'b1; cyc(); flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (byte_ready !== 1'b1 || fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL flush.empty ready=%0b wr=%0b want 1/0", byte_ready, fifo_wr_en); end
      foreach (q[i]) begin byte_in = q[i]; byte_valid = 1'b1; cyc(); end
      byte_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      n_cmp++; if (byte_cnt !== 2'd2) begin n_bad++; $display("FAIL flush.held got=%0d want=2", byte_cnt); end
      cyc(); flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL flush.wr_en got=%0b want=1", fifo_wr_en); end
      n_cmp++; if (fifo_data !== pack(q)) begin n_bad++; $display("FAIL flush.data got=%h want=%h", fifo_data, pack(q)); end
      n_cmp++; if (word_bytes !== 3'd2) begin n_bad++; $display("FAIL flush.word_bytes got=%0d want=2", word_bytes); end
      n_cmp++; if (byte_cnt !== 2'd0) begin n_bad++; $display("FAIL flush.byte_cnt got=%0d want=0", byte_cnt); end
      cyc();
      // flush together with a byte
      byte_in = one[0]; byte_valid = 1'b1; flush = 1'b1;
      cyc(); byte_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_data !== pack(one) || word_bytes !== 3'd1) begin
         n_bad++; $display("FAIL flush.with_byte wr=%0b data=%h bytes=%0d want 1/%h/1", fifo_wr_en, fifo_data, word_bytes, pack(one));
      end
      cyc();
      @(negedge clk);
      n_cmp++; if (word_count !== CNT_W'(2)) begin n_bad++; $display("FAIL flush.word_count got=%0d want=2", word_count); end
   endtask

   task automatic test_backpressure();
      bq_t q;
      logic [31:0] w;
      do_reset();
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      w = pack(q);
      fifo_full = 1'b1;
      foreach (q[i]) begin byte_in = q[i]; byte_valid = 1'b1; cyc(); end
      byte_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++; if (fifo_wr_en !== 1'b0 || byte_ready !== 1'b0 || fifo_data !== w || word_bytes !== 3'd4) begin
            n_bad++; $display("FAIL stall.hold c=%0d wr=%0b rdy=%0b data=%h bytes=%0d want 0/0/%h/4", c, fifo_wr_en, byte_ready, fifo_data, word_bytes, w);
         end
         cyc();
      end
      fifo_full = 1'b0;
      @(negedge clk);
      n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_data !== w) begin n_bad++; $display("FAIL stall.release wr=%0b data=%h want 1/%h", fifo_wr_en, fifo_data, w); end
      cyc();
      @(negedge clk);
      n_cmp++; if (fifo_wr_en !== 1'b0 || word_count !== CNT_W'(1)) begin n_bad++; $display("FAIL stall.single wr=%0b cnt=%0d want 0/1", fifo_wr_en, word_count); end
   endtask

   task automatic test_fifo_stall();
      logic [31:0] got[$];
      int sent = 0;
      do_reset();
      for (int c = 0; c < 60; c++) begin
         fifo_full  = (got.size() >= 8);
         byte_valid = (sent < 40);
         byte_in    = 8'(sent + 1);
         @(negedge clk);
         if (byte_valid && byte_ready) sent++;
         if (fifo_wr_en) got.push_back(fifo_data);
         cyc();
      end
      byte_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (got.size() != 8) begin n_bad++; $display("FAIL fifo_fill.words got=%0d want=8", got.size()); end
      n_cmp++; if (sent != 36) begin n_bad++; $display("FAIL fifo_fill.bytes_taken got=%0d want=36", sent); end
      n_cmp++; if (byte_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL fifo_fill.stalled rdy=%0b wr=%0b want 0/0", byte_ready, fifo_wr_en); end
      n_cmp++; if (word_count !== CNT_W'(8)) begin n_bad++; $display("FAIL fifo_fill.word_count got=%0d want=%0d", word_count, CNT_W'(8)); end
      foreach (got[w]) begin
         bq_t q;
         for (int k = 0; k < 4; k++) q.push_back(8'(4*w + k + 1));
         n_cmp++; if (got[w] !== pack(q)) begin n_bad++; $display("FAIL fifo_fill.word%0d got=%h want=%h", w, got[w], pack(q)); end
      end
   endtask

   task automatic test_reset_mid();
      bq_t q  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      bq_t q2 = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_reset();
      fifo_full = 1'b1;
      foreach (q[i]) begin byte_in = q[i]; byte_valid = 1'b1; cyc(); end
      byte_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (fifo_data !== pack(q)) begin n_bad++; $display("FAIL rst_mid.pending got=%h want=%h", fifo_data, pack(q)); end
      cyc();
      fifo_full = 1'b0; rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_mid.wr_en got=%0b want=0", fifo_wr_en); end
      cyc(); rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (byte_cnt !== 2'd0 || word_count !== '0 || byte_ready !== 1'b1 || fifo_wr_en !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid.after cnt=%0d wc=%0d rdy=%0b wr=%0b want 0/0/1/0", byte_cnt, word_count, byte_ready, fifo_wr_en);
      end
      foreach (q2[i]) begin byte_in = q2[i]; byte_valid = 1'b1; cyc(); end
      byte_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_data !== pack(q2)) begin n_bad++; $display("FAIL rst_mid.clean wr=%0b data=%h want 1/%h", fifo_wr_en, fifo_data, pack(q2)); end
      cyc();
   endtask

   task automatic test_wrap();
      int exp_seq[5] = '{1, 2, 3, 0, 1};
      do_reset();
      for (int w = 0; w < 5; w++) begin
         byte_in = 8'(w); byte_valid = 1'b1; flush = 1'b1;
         cyc(); byte_valid = 1'b0; flush = 1'b0;
         cyc();
         @(negedge clk);
         n_cmp++; if (word_count !== CNT_W'(exp_seq[w])) begin n_bad++; $display("FAIL wrap.word%0d got=%0d want=%0d", w, word_count, exp_seq[w]); end
      end
   endtask

   task automatic test_random();
      bq_t         held;
      bit          m_pend = 0;
      logic [31:0] m_word = '0;
      int          m_nb = 0;
      int          m_wc = 0;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         if (!(m_pend && byte_valid)) begin
            byte_valid = ($urandom_range(0, 3) != 0);
            byte_in    = 8'($urandom);
         end
         flush     = ($urandom_range(0, 5) == 0);
         fifo_full = ($urandom_range(0, 2) == 0);
         @(negedge clk);
         n_cmp++; if (byte_ready !== !m_pend) begin n_bad++; $display("FAIL rand.ready c=%0d got=%0b want=%0b", c, byte_ready, !m_pend); end
         n_cmp++; if (fifo_wr_en !== (m_pend && !fifo_full)) begin n_bad++; $display("FAIL rand.wr_en c=%0d got=%0b want=%0b", c, fifo_wr_en, m_pend && !fifo_full); end
         n_cmp++; if (byte_cnt !== 2'(held.size())) begin n_bad++; $display("FAIL rand.byte_cnt c=%0d got=%0d want=%0d", c, byte_cnt, held.size()); end
         n_cmp++; if (word_count !== CNT_W'(m_wc)) begin n_bad++; $display("FAIL rand.word_count c=%0d got=%0d want=%0d", c, word_count, CNT_W'(m_wc)); end
         if (m_pend) begin
            n_cmp++; if (fifo_data !== m_word || word_bytes !== 3'(m_nb)) begin
               n_bad++; $display("FAIL rand.word c=%0d data=%h bytes=%0d want %h/%0d", c, fifo_data, word_bytes, m_word, m_nb);
            end
         end
         if (m_pend) begin
            if (!fifo_full) begin m_pend = 0; m_wc++; end
         end else begin
            if (byte_valid) held.push_back(byte_in);
            if (held.size() == 4 || (flush && held.size() != 0)) begin
               m_word = pack(held); m_nb = held.size(); m_pend = 1; held.delete();
            end
         end
         cyc();
      end
      byte_valid = 1'b0; flush = 1'b0; fifo_full = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_flush();
      test_backpressure();
      test_fifo_stall();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
